// File: rtl/recorder_ctrl.sv
// ----------------------------------------------------------------------------
// recorder_ctrl
//   Sequencer for the voice recorder. It sits between the button synchronizer
//   and the sample RAM / audio codec interface. It records and plays back
//   per-slot audio, drives the sample-memory address and strobes, keeps the
//   recorded length of every slot and reports status.
//
// Optional feature (compile-time macro): LOOP_PLAY_EN
//   defined   : playback wraps to offset 0 after the last sample and keeps
//               looping until a ply or rec edge.
//   undefined : playback stops after the last recorded sample.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous reset, active-low
//   rec          in   synchronized record button level
//   ply          in   synchronized play button level
//   num          in   synchronized slot-select button level
//   sample_tick  in   one-cycle strobe at the sample rate
//   mem_addr     out  {slot, offset}
//   mem_we       out  write strobe, sample captured at mem_addr
//   mem_re       out  read strobe, data at mem_addr requested
//   slot         out  currently selected slot
//   recording    out  state == REC
//   playing      out  state == PLAY
//   full         out  selected slot holds SLOT_DEPTH samples
// ----------------------------------------------------------------------------
module recorder_ctrl #(
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_DEPTH = 32768
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   rec,
    input  logic                                                   ply,
    input  logic                                                   num,
    input  logic                                                   sample_tick,
    output logic [$clog2(NUM_SLOTS)+$clog2(SLOT_DEPTH)-1:0]        mem_addr,
    output logic                                                   mem_we,
    output logic                                                   mem_re,
    output logic [$clog2(NUM_SLOTS)-1:0]                           slot,
    output logic                                                   recording,
    output logic                                                   playing,
    output logic                                                   full
);

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int OFF_W  = $clog2(SLOT_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REC  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    state_t              r_state;
    logic [SLOT_W-1:0]   r_slot;
    logic [OFF_W-1:0]    r_offset;
    logic [OFF_W:0]      r_len [NUM_SLOTS];
    logic                r_rec_q;
    logic                r_ply_q;
    logic                r_num_q;

    logic                w_rec_edge;
    logic                w_ply_edge;
    logic                w_num_edge;
    logic                w_stop;
    logic [OFF_W:0]      w_cur_len;
    logic [OFF_W:0]      w_off_next;
    logic                w_wr;
    logic                w_rd;
    logic                w_last_rd;

    // Rising-edge detect against the previous level.
    assign w_rec_edge = rec & ~r_rec_q;
    assign w_ply_edge = ply & ~r_ply_q;
    assign w_num_edge = num & ~r_num_q;

    // Either button ends a running operation; the tick of that cycle is dropped.
    assign w_stop     = w_rec_edge | w_ply_edge;

    assign w_cur_len  = r_len[r_slot];
    assign w_off_next = {1'b0, r_offset} + (OFF_W+1)'(1);
    assign w_last_rd  = (w_off_next == w_cur_len);

    // Strobes are combinational so they coincide with the sample_tick cycle.
    // Gating with rst keeps them low while reset is being applied.
    assign w_wr = rst && (r_state == S_REC)  && sample_tick && !w_stop;
    assign w_rd = rst && (r_state == S_PLAY) && sample_tick && !w_stop;

    assign mem_we    = w_wr;
    assign mem_re    = w_rd;
    assign mem_addr  = {r_slot, r_offset};
    assign slot      = r_slot;
    assign recording = (r_state == S_REC);
    assign playing   = (r_state == S_PLAY);
    assign full      = (w_cur_len == (OFF_W+1)'(SLOT_DEPTH));

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_slot   <= '0;
            r_offset <= '0;
            // History set high: a button held through reset yields no edge.
            r_rec_q  <= 1'b1;
            r_ply_q  <= 1'b1;
            r_num_q  <= 1'b1;
            // NOTE: the length table is a small register array, not RAM, so it
            // is reset explicitly; an aborted recording must read back as empty.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_len[i] <= '0;
            end
        end else begin
            r_rec_q <= rec;
            r_ply_q <= ply;
            r_num_q <= num;

            case (r_state)
                S_IDLE: begin
                    if (w_rec_edge) begin
                        r_state       <= S_REC;
                        r_offset      <= '0;
                        r_len[r_slot] <= '0;
                    end else if (w_ply_edge) begin
                        // An empty slot has nothing to play; the edge is ignored.
                        if (w_cur_len != '0) begin
                            r_state  <= S_PLAY;
                            r_offset <= '0;
                        end
                    end else if (w_num_edge) begin
                        // Power-of-two slot count: natural overflow is the wrap.
                        r_slot <= r_slot + SLOT_W'(1);
                    end
                end

                S_REC: begin
                    if (w_stop) begin
                        r_state <= S_IDLE;
                    end else if (sample_tick) begin
                        // Length tracks offset+1, so it saturates at SLOT_DEPTH
                        // on the final write and never wraps.
                        r_len[r_slot] <= w_off_next;
                        if (&r_offset) begin
                            r_state  <= S_IDLE;
                            r_offset <= '0;
                        end else begin
                            r_offset <= r_offset + OFF_W'(1);
                        end
                    end
                end

                S_PLAY: begin
                    if (w_stop) begin
                        // rec_edge here only stops playback; it never records.
                        r_state <= S_IDLE;
                    end else if (sample_tick) begin
                        if (w_last_rd) begin
`ifdef LOOP_PLAY_EN
                            r_offset <= '0;
`else
                            r_state  <= S_IDLE;
`endif
                        end else begin
                            r_offset <= r_offset + OFF_W'(1);
                        end
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_recorder_ctrl.sv
// ----------------------------------------------------------------------------
// tb_recorder_ctrl
//   Directed bench for recorder_ctrl (NUM_SLOTS=4, SLOT_DEPTH=8). Memory
//   strobes are checked by a scoreboard: stimulus pushes the expected
//   {write, address} for every tick, a negedge monitor pops on each strobe.
//   Status outputs are checked directly by the stimulus with check().
// ----------------------------------------------------------------------------
module tb_recorder_ctrl;

    localparam int NUM_SLOTS  = 4;
    localparam int SLOT_DEPTH = 8;
    localparam int SLOT_W     = 2;
    localparam int OFF_W      = 3;
    localparam int ADDR_W     = SLOT_W + OFF_W;

    typedef struct packed {
        logic              is_wr;
        logic [ADDR_W-1:0] addr;
    } mem_txn_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rec = 1'b0;
    logic              ply = 1'b0;
    logic              num = 1'b0;
    logic              sample_tick = 1'b0;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [SLOT_W-1:0] slot;
    logic              recording;
    logic              playing;
    logic              full;

    int n_checks = 0;
    int n_errors = 0;
    mem_txn_t exp_q[$];

    recorder_ctrl #(
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_DEPTH (SLOT_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rec         (rec),
        .ply         (ply),
        .num         (num),
        .sample_tick (sample_tick),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .slot        (slot),
        .recording   (recording),
        .playing     (playing),
        .full        (full)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the oldest expected transaction.
    always @(negedge clk) begin
        if (mem_we && mem_re) begin
            n_checks++;
            n_errors++;
            $display("FAIL both_strobes: mem_we and mem_re both high at addr 0x%0h", mem_addr);
        end else if (mem_we || mem_re) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_strobe: we=%0b re=%0b addr 0x%0h, none expected",
                         mem_we, mem_re, mem_addr);
            end else begin
                mem_txn_t e;
                e = exp_q.pop_front();
                check("mem_txn", {26'd0, mem_we, mem_addr}, {26'd0, e.is_wr, e.addr});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One-cycle button/tick pattern followed by one idle cycle.
    task automatic press(input logic r, input logic p, input logic nn, input logic tk);
        rec = r; ply = p; num = nn; sample_tick = tk;
        step(1);
        rec = 1'b0; ply = 1'b0; num = 1'b0; sample_tick = 1'b0;
        step(1);
    endtask

    task automatic tick_expect(input logic push, input logic is_wr, input logic [ADDR_W-1:0] addr);
        if (push) exp_q.push_back('{is_wr: is_wr, addr: addr});
        press(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        // 1. rec held through reset release: no edge, stays IDLE on slot 0.
        rec = 1'b1;
        step(3);
        rst = 1'b1;
        step(3);
        check("rst_recording", recording, 0);
        check("rst_playing", playing, 0);
        check("rst_slot", slot, 0);
        check("rst_addr", mem_addr, 0);
        rec = 1'b0;
        step(2);
        check("held_rec_no_edge", recording, 0);

        // 2. Record 5 samples in slot 0, then play them back with 7 ticks.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("rec_start", recording, 1);
        for (int i = 0; i < 5; i++) tick_expect(1'b1, 1'b1, ADDR_W'(i));
        // Stop edge coincides with a tick: that tick is not written.
        press(1'b1, 1'b0, 1'b0, 1'b1);
        check("rec_stop", recording, 0);
        check("len5_not_full", full, 0);

        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("play_start", playing, 1);
        for (int i = 0; i < 7; i++) begin
`ifdef LOOP_PLAY_EN
            tick_expect(1'b1, 1'b0, ADDR_W'(i % 5));
`else
            tick_expect(i < 5, 1'b0, ADDR_W'(i));
            if (i == 4) check("play_end_after_5th", playing, 0);
`endif
        end
`ifdef LOOP_PLAY_EN
        check("loop_still_playing", playing, 1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
`endif
        check("play_idle", playing, 0);

        // 3. Slot selection wraps; num ignored during REC.
        for (int i = 0; i < 3; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
        check("slot3", slot, 3);
        check("addr_msb3", {30'd0, mem_addr[ADDR_W-1 -: SLOT_W]}, 3);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("slot_wrap", slot, 0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("num_in_rec", slot, 0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        // Slot 0 re-recorded with zero samples: play is ignored.
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("play_empty", playing, 0);

        // 4. Fill slot 0: 10 ticks give exactly 8 writes, then full.
        press(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) tick_expect(i < 8, 1'b1, ADDR_W'(i));
        check("fill_idle", recording, 0);
        check("fill_full", full, 1);

        // rec edge during PLAY stops playback and does not start recording.
        press(1'b0, 1'b1, 1'b0, 1'b0);
        tick_expect(1'b1, 1'b0, ADDR_W'(0));
        press(1'b1, 1'b0, 1'b0, 1'b1);
        check("rec_in_play_playing", playing, 0);
        check("rec_in_play_recording", recording, 0);
        check("rec_in_play_len_kept", full, 1);

        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("slot1_not_full", full, 0);

        // 5. rec and ply together in IDLE -> REC; reset aborts after 3 writes.
        press(1'b1, 1'b1, 1'b0, 1'b0);
        check("prio_recording", recording, 1);
        check("prio_playing", playing, 0);
        for (int i = 0; i < 3; i++) tick_expect(1'b1, 1'b1, ADDR_W'(8 + i));
        rst = 1'b0;
        sample_tick = 1'b1;
        step(1);
        check("abort_mem_we", mem_we, 0);
        sample_tick = 1'b0;
        rst = 1'b1;
        step(1);
        check("abort_idle", recording, 0);
        check("abort_slot", slot, 0);
        check("abort_len_cleared", full, 0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("abort_slot1_empty", playing, 0);

        step(2);
        check("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Backstop so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
